taxi_episode_runner: RTL and testbench

Agent-side driver for the `TaxiStep` environment core. It holds the current Taxi-v3 observation, accepts actions from a policy through a valid/ready handshake, and presents state plus action to `TaxiStep`. It captures the next state, reward and terminated flag, accumulates the episode return, counts steps, and ends the episode on termination or on step-limit truncation. It sits between the policy engine and `TaxiStep` in the FPGA_Gym Taxi pipeline.

---
 rtl/taxi_episode_runner.sv | 240 ++++++++++++++++++++++++
 tb/tb_taxi_episode_runner.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_episode_runner.sv
// taxi_episode_runner
// Agent-side episode driver for the TaxiStep environment core. It holds the
// current Taxi-v3 observation, takes actions from a policy over a valid/ready
// handshake and presents state plus action to TaxiStep. After STEP_LAT cycles
// it captures the next state, reward and terminated flag. It also accumulates a
// saturating signed return, counts steps, and ends the episode on termination
// or on step-limit truncation.
//
// Ports
//   clk, reset            : clock (rising edge), synchronous active-high reset
//   start, init_*         : begin an episode from the given state (IDLE/DONE only)
//   action_valid/_ready   : policy action handshake; action 0..5 legal
//   step_req, step_*      : one-cycle request plus state/action to TaxiStep
//   res_*                 : next state, reward code, terminated flag from TaxiStep
//   obs_*                 : current observation
//   ep_return, step_count : signed running return, steps this episode
//   done/terminated/truncated : episode end status, held until next start
//   illegal_action, init_err, proto_err : one-cycle error pulses
module taxi_episode_runner #(
   parameter int unsigned MAX_STEPS = 200,
   parameter int unsigned STEP_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  init_row,
   input  logic [2:0]  init_col,
   input  logic [2:0]  init_pass,
   input  logic [1:0]  init_dest,
   input  logic        action_valid,
   input  logic [2:0]  action,
   output logic        action_ready,
   output logic        step_req,
   output logic [2:0]  step_action,
   output logic [2:0]  step_row,
   output logic [2:0]  step_col,
   output logic [2:0]  step_pass,
   output logic [1:0]  step_dest,
   input  logic [2:0]  res_row,
   input  logic [2:0]  res_col,
   input  logic [2:0]  res_pass,
   input  logic [1:0]  res_dest,
   input  logic [1:0]  res_reward,
   input  logic        res_terminated,
   output logic [2:0]  obs_row,
   output logic [2:0]  obs_col,
   output logic [2:0]  obs_pass,
   output logic [1:0]  obs_dest,
   output logic [11:0] ep_return,
   output logic [7:0]  step_count,
   output logic        done,
   output logic        terminated,
   output logic        truncated,
   output logic        illegal_action,
   output logic        init_err,
   output logic        proto_err
);

   typedef enum logic [2:0] {IDLE, WAIT_ACT, ISSUE, WAIT_RES, DONE} state_t;

   localparam logic [7:0] MAX_CNT  = 8'(MAX_STEPS);
   localparam logic [2:0] LAT_LAST = 3'(STEP_LAT - 1);

   state_t             state_q, state_d;
   logic [2:0]         row_q, row_d, col_q, col_d, pass_q, pass_d;
   logic [1:0]         dest_q, dest_d;
   logic [2:0]         act_q, act_d;
   logic [2:0]         lat_q, lat_d;
   logic signed [11:0] ret_q, ret_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               done_q, done_d, term_q, term_d, trunc_q, trunc_d;
   logic               illegal_q, illegal_d, init_err_q, init_err_d;
   logic               proto_q, proto_d;

   logic               init_ok;
   logic signed [12:0] reward;
   logic signed [12:0] ret_sum;
   logic [7:0]         cnt_inc;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      pass_d     = pass_q;
      dest_d     = dest_q;
      act_d      = act_q;
      lat_d      = lat_q;
      ret_d      = ret_q;
      cnt_d      = cnt_q;
      done_d     = done_q;
      term_d     = term_q;
      trunc_d    = trunc_q;
      illegal_d  = 1'b0;
      init_err_d = 1'b0;
      proto_d    = 1'b0;

      // pass == 4 (in taxi) can never equal a 2-bit destination index
      init_ok = (init_row <= 3'd4) && (init_col <= 3'd4) && (init_pass <= 3'd4)
                && (init_pass != {1'b0, init_dest});

      case (res_reward)
         2'd0:    reward = -13'sd1;
         2'd1:    reward = 13'sd20;
         2'd2:    reward = -13'sd10;
         default: reward = 13'sd0;
      endcase
      // one guard bit so overflow is visible before clamping
      ret_sum = {ret_q[11], ret_q} + reward;
      cnt_inc = cnt_q + 8'd1;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               if (init_ok) begin
                  row_d   = init_row;
                  col_d   = init_col;
                  pass_d  = init_pass;
                  dest_d  = init_dest;
                  ret_d   = '0;
                  cnt_d   = '0;
                  done_d  = 1'b0;
                  term_d  = 1'b0;
                  trunc_d = 1'b0;
                  state_d = WAIT_ACT;
               end else begin
                  init_err_d = 1'b1;
               end
            end
         end
         WAIT_ACT: begin
            if (action_valid) begin
               if (action <= 3'd5) begin
                  act_d   = action;
                  state_d = ISSUE;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            lat_d   = '0;
            state_d = WAIT_RES;
         end
         WAIT_RES: begin
            if (lat_q == LAT_LAST) begin
               row_d   = res_row;
               col_d   = res_col;
               pass_d  = res_pass;
               dest_d  = res_dest;
               cnt_d   = cnt_inc;
               proto_d = (res_reward == 2'd3);
               if (ret_sum > 13'sd2047)
                  ret_d = 12'sd2047;
               else if (ret_sum < -13'sd2048)
                  ret_d = -12'sd2048;
               else
                  ret_d = $signed(ret_sum[11:0]);
               // termination takes priority when it coincides with the limit
               if (res_terminated) begin
                  term_d  = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else if (cnt_inc == MAX_CNT) begin
                  trunc_d = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = WAIT_ACT;
               end
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value; all of them reset, as every output must read 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         pass_q     <= '0;
         dest_q     <= '0;
         act_q      <= '0;
         lat_q      <= '0;
         ret_q      <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         term_q     <= 1'b0;
         trunc_q    <= 1'b0;
         illegal_q  <= 1'b0;
         init_err_q <= 1'b0;
         proto_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         pass_q     <= pass_d;
         dest_q     <= dest_d;
         act_q      <= act_d;
         lat_q      <= lat_d;
         ret_q      <= ret_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         term_q     <= term_d;
         trunc_q    <= trunc_d;
         illegal_q  <= illegal_d;
         init_err_q <= init_err_d;
         proto_q    <= proto_d;
      end
   end

   // The observation is untouched between ISSUE and capture, so the step
   // outputs stay constant for the whole request.
   assign action_ready   = (state_q == WAIT_ACT);
   assign step_req       = (state_q == ISSUE);
   assign step_action    = act_q;
   assign step_row       = row_q;
   assign step_col       = col_q;
   assign step_pass      = pass_q;
   assign step_dest      = dest_q;
   assign obs_row        = row_q;
   assign obs_col        = col_q;
   assign obs_pass       = pass_q;
   assign obs_dest       = dest_q;
   assign ep_return      = ret_q;
   assign step_count     = cnt_q;
   assign done           = done_q;
   assign terminated     = term_q;
   assign truncated      = trunc_q;
   assign illegal_action = illegal_q;
   assign init_err       = init_err_q;
   assign proto_err      = proto_q;

endmodule

// File: tb/tb_taxi_episode_runner.sv
// Testbench for taxi_episode_runner: the bench plays TaxiStep by driving the
// res_* inputs, keeps its own episode model, and checks every completed step
// against an expected-result queue.
module tb_taxi_episode_runner;

   localparam int MAX_STEPS = 3;
   localparam int STEP_LAT  = 1;

   logic        clk, reset, start;
   logic [2:0]  init_row, init_col, init_pass;
   logic [1:0]  init_dest;
   logic        action_valid;
   logic [2:0]  action;
   logic        action_ready, step_req;
   logic [2:0]  step_action, step_row, step_col, step_pass;
   logic [1:0]  step_dest;
   logic [2:0]  res_row, res_col, res_pass;
   logic [1:0]  res_dest, res_reward;
   logic        res_terminated;
   logic [2:0]  obs_row, obs_col, obs_pass;
   logic [1:0]  obs_dest;
   logic [11:0] ep_return;
   logic [7:0]  step_count;
   logic        done, terminated, truncated, illegal_action, init_err, proto_err;

   taxi_episode_runner #(.MAX_STEPS(MAX_STEPS), .STEP_LAT(STEP_LAT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .init_row(init_row), .init_col(init_col), .init_pass(init_pass), .init_dest(init_dest),
      .action_valid(action_valid), .action(action), .action_ready(action_ready),
      .step_req(step_req), .step_action(step_action),
      .step_row(step_row), .step_col(step_col), .step_pass(step_pass), .step_dest(step_dest),
      .res_row(res_row), .res_col(res_col), .res_pass(res_pass), .res_dest(res_dest),
      .res_reward(res_reward), .res_terminated(res_terminated),
      .obs_row(obs_row), .obs_col(obs_col), .obs_pass(obs_pass), .obs_dest(obs_dest),
      .ep_return(ep_return), .step_count(step_count),
      .done(done), .terminated(terminated), .truncated(truncated),
      .illegal_action(illegal_action), .init_err(init_err), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int row, col, pass, dest, ret, cnt, done, term, trunc, proto;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // bench-side episode model
   int m_row, m_col, m_pass, m_dest, m_ret, m_cnt, m_done, m_term, m_trunc;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic int decode(input int code);
      case (code)
         0:       return -1;
         1:       return 20;
         2:       return -10;
         default: return 0;
      endcase
   endfunction

   task automatic model_clear();
      m_row = 0; m_col = 0; m_pass = 0; m_dest = 0;
      m_ret = 0; m_cnt = 0; m_done = 0; m_term = 0; m_trunc = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".obs"}, {obs_row, obs_col, obs_pass, obs_dest}, 0);
      check({tag, ".ret"}, $signed(ep_return), 0);
      check({tag, ".cnt"}, step_count, 0);
      check({tag, ".flags"}, {done, terminated, truncated}, 0);
      check({tag, ".pulses"}, {illegal_action, init_err, proto_err}, 0);
      check({tag, ".ready"}, action_ready, 0);
      check({tag, ".req"}, step_req, 0);
      check({tag, ".step"}, {step_action, step_row, step_col, step_pass, step_dest}, 0);
   endtask

   task automatic check_obs(input string tag);
      check({tag, ".obs"}, {obs_row, obs_col, obs_pass, obs_dest},
            {m_row[2:0], m_col[2:0], m_pass[2:0], m_dest[1:0]});
      check({tag, ".ret"}, $signed(ep_return), m_ret);
      check({tag, ".cnt"}, step_count, m_cnt);
      check({tag, ".flags"}, {done, terminated, truncated},
            {m_done[0], m_term[0], m_trunc[0]});
   endtask

   // Called just after a negedge in IDLE/DONE; returns just after a negedge.
   task automatic do_start(input int r, c, p, d, input int ok);
      init_row = 3'(r); init_col = 3'(c); init_pass = 3'(p); init_dest = 2'(d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (ok != 0) begin
         model_clear();
         m_row = r; m_col = c; m_pass = p; m_dest = d;
      end
      check("start.init_err", init_err, (ok != 0) ? 0 : 1);
      check("start.ready", action_ready, (ok != 0) ? 1 : 0);
      check_obs("start");
   endtask

   // One legal action through to its result; called just after a negedge in WAIT_ACT.
   task automatic do_step(input int a, rr, rc, rp, rd, code, term);
      exp_t e;
      int   pre_row, pre_col, pre_pass, pre_dest;
      int   req_n, lat;
      bit   fin;
      pre_row = m_row; pre_col = m_col; pre_pass = m_pass; pre_dest = m_dest;
      m_row = rr; m_col = rc; m_pass = rp; m_dest = rd;
      m_ret = m_ret + decode(code);
      if (m_ret > 2047)  m_ret = 2047;
      if (m_ret < -2048) m_ret = -2048;
      m_cnt++;
      m_term  = (term != 0) ? 1 : 0;
      m_trunc = (term == 0 && m_cnt == MAX_STEPS) ? 1 : 0;
      m_done  = m_term | m_trunc;
      e = '{m_row, m_col, m_pass, m_dest, m_ret, m_cnt, m_done, m_term, m_trunc,
            (code == 3) ? 1 : 0};
      sb.push_back(e);

      check("step.ready_before", action_ready, 1);
      res_row = 3'(rr); res_col = 3'(rc); res_pass = 3'(rp); res_dest = 2'(rd);
      res_reward = 2'(code); res_terminated = term[0];
      action = 3'(a); action_valid = 1'b1;
      @(negedge clk);
      action_valid = 1'b0;
      req_n = 0; lat = 1; fin = 1'b0;
      for (int i = 0; i < 20 && !fin; i++) begin
         if (step_req) begin
            req_n++;
            check("step.action", step_action, a);
            check("step.state", {step_row, step_col, step_pass, step_dest},
                  {pre_row[2:0], pre_col[2:0], pre_pass[2:0], pre_dest[1:0]});
         end
         if (action_ready || done) fin = 1'b1;
         else begin
            if (!step_req)
               check("step.hold", {step_row, step_col, step_pass, step_dest},
                     {pre_row[2:0], pre_col[2:0], pre_pass[2:0], pre_dest[1:0]});
            @(negedge clk);
            lat++;
         end
      end
      check("step.finished", fin, 1);
      check("step.req_cycles", req_n, 1);
      check("step.latency", lat, STEP_LAT + 2);
      e = sb.pop_front();
      check("sb.obs", {obs_row, obs_col, obs_pass, obs_dest},
            {e.row[2:0], e.col[2:0], e.pass[2:0], e.dest[1:0]});
      check("sb.ret", $signed(ep_return), e.ret);
      check("sb.cnt", step_count, e.cnt);
      check("sb.flags", {done, terminated, truncated}, {e.done[0], e.term[0], e.trunc[0]});
      check("sb.ready", action_ready, (e.done != 0) ? 0 : 1);
      check("sb.proto", proto_err, e.proto);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; action_valid = 1'b0; action = '0;
      init_row = '0; init_col = '0; init_pass = '0; init_dest = '0;
      res_row = '0; res_col = '0; res_pass = '0; res_dest = '0;
      res_reward = '0; res_terminated = 1'b0;
      model_clear();

      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_zero("reset");
      repeat (10) @(negedge clk);
      check_zero("idle10");

      // invalid init in IDLE: pass == dest
      do_start(0, 0, 1, 1, 0);
      @(negedge clk);
      check("init_err.pulse_end", init_err, 0);

      // episode 1: one -1 step, then a terminating +20 step
      do_start(2, 0, 2, 3, 1);
      do_step(1, 1, 0, 2, 3, 0, 0);
      check("ep1.ret_m1", $signed(ep_return), -1);
      check("ep1.cnt1", step_count, 1);
      do_step(5, 1, 0, 3, 3, 1, 1);
      check("ep1.ret_19", $signed(ep_return), 19);
      check("ep1.term", {done, terminated, truncated}, 3'b110);
      action = 3'd0; action_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("done.no_ready", action_ready, 0);
         check("done.no_req", step_req, 0);
      end
      action_valid = 1'b0;
      check_obs("done.held");

      // invalid init in DONE keeps everything
      do_start(0, 0, 2, 2, 0);

      // episode 2: illegal action, protocol error, -10, then terminate on the limit
      do_start(4, 4, 4, 0, 1);
      action = 3'd7; action_valid = 1'b1;
      @(negedge clk);
      action_valid = 1'b0;
      check("illegal.pulse", illegal_action, 1);
      check("illegal.no_req", step_req, 0);
      check("illegal.ready", action_ready, 1);
      check("illegal.cnt", step_count, 0);
      @(negedge clk);
      check("illegal.pulse_end", illegal_action, 0);
      check("illegal.still_no_req", step_req, 0);
      // start in WAIT_ACT is ignored
      init_row = 3'd0; init_col = 3'd0; init_pass = 3'd0; init_dest = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_obs("start_ignored");
      do_step(0, 3, 4, 4, 0, 3, 0);
      check("proto.ret_unchanged", $signed(ep_return), 0);
      do_step(2, 3, 4, 4, 0, 2, 0);
      do_step(4, 3, 4, 4, 0, 1, 1);
      check("coincide.flags", {done, terminated, truncated}, 3'b110);
      check("coincide.ret", $signed(ep_return), 10);

      // episode 3: truncation after three -1 steps
      do_start(0, 4, 0, 2, 1);
      do_step(0, 1, 4, 0, 2, 0, 0);
      do_step(0, 2, 4, 0, 2, 0, 0);
      do_step(0, 3, 4, 0, 2, 0, 0);
      check("trunc.flags", {done, terminated, truncated}, 3'b101);
      check("trunc.ret", $signed(ep_return), -3);

      // reset during WAIT_RES discards the in-flight result
      do_start(2, 2, 0, 3, 1);
      res_row = 3'd4; res_col = 3'd4; res_pass = 3'd1; res_dest = 2'd2;
      res_reward = 2'd1; res_terminated = 1'b0;
      action = 3'd2; action_valid = 1'b1;
      @(negedge clk);
      action_valid = 1'b0;
      check("rst_mid.issue", step_req, 1);
      @(negedge clk);
      check("rst_mid.wait_res", step_req, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      check_zero("rst_mid");
      @(negedge clk);
      check_zero("rst_mid.after");
      do_start(0, 0, 0, 1, 1);
      check("restart.cnt", step_count, 0);
      do_step(1, 0, 0, 0, 1, 0, 0);

      check("sb.empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
